fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning): addressWidth, 64, address bits; instructionWidth, 32, instruction bits; maxBundleSize, 128, bundle bits (4 instructions); PidSize, 32, process id bits; TidSize, 64, thread id bits; instructionCounterWidth, 64, major-id counter bits; resetVector, 0, PC after reset; fetchUnitInstance, 0, debug tag.
REQ-002 There SHALL be one clock and the reset SHALL be synchronous and active-high; ports SHALL be named clock_i and reset_i.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- pid_i  in  PidSize  current process id
- tid_i  in  TidSize  current thread id
- redirect_i  in  1  change fetch PC (branch or exception)
- redirectAddr_i  in  addressWidth  new PC; bits [62:63] ignored
- icacheReq_o  out  1  request valid
- icacheAddr_o  out  addressWidth  PC with bits [60:63] zeroed (16-byte aligned)
- icacheReady_i  in  1  request accepted this cycle
- icacheValid_i  in  1  response data valid
- icacheData_i  in  maxBundleSize  aligned 16 bytes, word 0 at bits [0:31]
- queueFull_i  in  1  fetch queue cannot accept a bundle
- bundleWrite_o  out  1  one-cycle write strobe to queue
- bundleAddress_o  out  addressWidth  address of first instruction in bundle
- bundleLen_o  out  2  instruction count minus 1
- bundlePid_o  out  PidSize  pid_i sampled at write
- bundleTid_o  out  TidSize  tid_i sampled at write
- bundleStartMajId_o  out  instructionCounterWidth  major id of first instruction
- bundle_o  out  maxBundleSize  instructions, first at bits [0:31]

Function
REQ-004 State machine SHALL have states IDLE, REQ, WAIT, STALL and DRAIN.
REQ-005 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-006 icacheReq_o SHALL equal (state==REQ) and !reset_i.
REQ-007 In REQ with icacheReady_i=1, the state SHALL go to WAIT; otherwise it SHALL stay in REQ with the address held.
REQ-008 With off = PC[60:61], the bundle SHALL hold 4-off instructions, bundleLen_o SHALL be 3-off, and bundle_o SHALL be icacheData_i shifted left by off*32 with vacated low words zero.
REQ-009 In WAIT with icacheValid_i=1 and queueFull_i=0, at that edge:
- bundleWrite_o<=1; bundle fields loaded; bundleAddress_o<=PC
- PC<=(PC with bits [60:63] cleared)+16
- majId<=majId+(4-off)
- state<=REQ
REQ-010 In WAIT with icacheValid_i=1 and queueFull_i=1, data, PC and off SHALL be captured into a hold buffer, and the state SHALL go to STALL with no write.
REQ-011 In STALL, on the first edge with queueFull_i=0, the write SHALL be performed from the hold buffer per REQ-009 and the state SHALL go to REQ; no cache request SHALL be issued while in STALL.
REQ-012 bundleWrite_o SHALL be 0 in every cycle not covered by REQ-009 or REQ-011; other bundle outputs SHALL hold their last value.
REQ-013 redirect_i SHALL take priority over all other transitions in every state, and it SHALL:
- load PC with redirectAddr_i, bits [62:63] zeroed
- suppress any write that edge
- discard the hold buffer
REQ-014 On redirect, the next state SHALL be DRAIN if in WAIT, or if in REQ with icacheReady_i=1 that cycle; if already in DRAIN it SHALL stay DRAIN; otherwise it SHALL be REQ.
REQ-015 In DRAIN, the first icacheValid_i=1 SHALL be discarded (no write) and the state SHALL go to REQ.
REQ-016 The majId counter SHALL wrap modulo 2^instructionCounterWidth and SHALL NOT rewind on redirect.
REQ-017 At most one request SHALL be outstanding at any time.

Reset
REQ-018 While reset_i=1 at an edge, the state SHALL become IDLE, PC SHALL become resetVector, majId SHALL become 0, the hold buffer SHALL be cleared, and all outputs SHALL be 0 (icacheReq_o 0).
REQ-019 Reset SHALL override redirect and pending responses; a response arriving after reset with no post-reset request SHALL be ignored.

Verification
REQ-020 Reset, resetVector=0x1000 -> all outputs 0; one cycle later icacheReq_o=1 with icacheAddr_o=0x1000.
REQ-021 Ready, then valid with {A,B,C,D}, queueFull_i=0 -> single bundleWrite_o pulse: address 0x1000, len 2'b11, bundle {A,B,C,D}, majId 0; next request at 0x1010; next majId 4.
REQ-022 Redirect to 0x200A, then data {W,X,Y,Z} -> bundle {Y,Z,0,0}, len 2'b01, address 0x2008; next request at 0x2010.
REQ-023 Valid while queueFull_i=1 for 3 cycles -> no write and icacheReq_o=0 during the stall; full deasserts -> write of the held data on the next edge.
REQ-024 Redirect to 0x3000 in WAIT -> the later response is discarded with no write; the next request is at 0x3000.
REQ-025 Reset asserted while in STALL -> the held bundle is never written; the fetch restarts at resetVector.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: process context, redirect, icache request/response and bundle-queue write.
// The master modport is the fetch unit's view; slave is the environment's view.
interface fetch_unit_if #(
    parameter int addressWidth            = 64,
    parameter int maxBundleSize           = 128,
    parameter int PidSize                 = 32,
    parameter int TidSize                 = 64,
    parameter int instructionCounterWidth = 64
) ();
    logic [PidSize-1:0]                 pid_i;
    logic [TidSize-1:0]                 tid_i;
    logic                               redirect_i;
    logic [addressWidth-1:0]            redirectAddr_i;
    logic                               icacheReq_o;
    logic [addressWidth-1:0]            icacheAddr_o;
    logic                               icacheReady_i;
    logic                               icacheValid_i;
    logic [maxBundleSize-1:0]           icacheData_i;
    logic                               queueFull_i;
    logic                               bundleWrite_o;
    logic [addressWidth-1:0]            bundleAddress_o;
    logic [1:0]                         bundleLen_o;
    logic [PidSize-1:0]                 bundlePid_o;
    logic [TidSize-1:0]                 bundleTid_o;
    logic [instructionCounterWidth-1:0] bundleStartMajId_o;
    logic [maxBundleSize-1:0]           bundle_o;

    modport master (
        input  pid_i, tid_i, redirect_i, redirectAddr_i,
               icacheReady_i, icacheValid_i, icacheData_i, queueFull_i,
        output icacheReq_o, icacheAddr_o, bundleWrite_o, bundleAddress_o,
               bundleLen_o, bundlePid_o, bundleTid_o, bundleStartMajId_o, bundle_o
    );

    modport slave (
        output pid_i, tid_i, redirect_i, redirectAddr_i,
               icacheReady_i, icacheValid_i, icacheData_i, queueFull_i,
        input  icacheReq_o, icacheAddr_o, bundleWrite_o, bundleAddress_o,
               bundleLen_o, bundlePid_o, bundleTid_o, bundleStartMajId_o, bundle_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one 16-byte aligned icache request at a time and writes
// the fetched instructions (from the PC's word offset onward) as a bundle into the fetch queue.
module fetch_unit #(
    parameter int                      addressWidth            = 64,
    parameter int                      instructionWidth        = 32,
    parameter int                      maxBundleSize           = 128,
    parameter int                      PidSize                 = 32,
    parameter int                      TidSize                 = 64,
    parameter int                      instructionCounterWidth = 64,
    parameter logic [addressWidth-1:0] resetVector             = '0,
    parameter int                      fetchUnitInstance       = 0
) (
    input logic          clock_i,
    input logic          reset_i,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, STALL, DRAIN} stateType;

    stateType                           state;
    logic [addressWidth-1:0]            pc;
    logic [addressWidth-1:0]            holdPc;
    logic [maxBundleSize-1:0]           holdData;
    logic [instructionCounterWidth-1:0] majId;

    logic [addressWidth-1:0]            srcPc;
    logic [maxBundleSize-1:0]           srcData;
    logic [1:0]                         srcOff;
    logic                               writeNow;
    logic                               unusedRedirectBits;

    if (maxBundleSize != 4 * instructionWidth) begin : gBadBundle
        $error("fetch_unit: maxBundleSize must hold exactly four instructions");
    end
    if (fetchUnitInstance < 0) begin : gBadInstance
        $error("fetch_unit: fetchUnitInstance must be non-negative");
    end

    assign unusedRedirectBits = ^bus.redirectAddr_i[1:0];

    assign bus.icacheReq_o  = (state == REQ) && !reset_i;
    assign bus.icacheAddr_o = bus.icacheReq_o ? {pc[addressWidth-1:4], 4'b0000} : '0;

    // A stalled bundle is written from the hold buffer; otherwise straight from the response.
    always_comb begin
        srcPc   = (state == STALL) ? holdPc   : pc;
        srcData = (state == STALL) ? holdData : bus.icacheData_i;
    end
    assign srcOff   = srcPc[3:2];
    assign writeNow = !reset_i && !bus.redirect_i && !bus.queueFull_i &&
                      ((state == WAIT && bus.icacheValid_i) || state == STALL);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state                  <= IDLE;
            pc                     <= resetVector;
            majId                  <= '0;
            holdPc                 <= '0;
            holdData               <= '0;
            bus.bundleWrite_o      <= 1'b0;
            bus.bundleAddress_o    <= '0;
            bus.bundleLen_o        <= '0;
            bus.bundlePid_o        <= '0;
            bus.bundleTid_o        <= '0;
            bus.bundleStartMajId_o <= '0;
            bus.bundle_o           <= '0;
        end else begin
            bus.bundleWrite_o <= 1'b0;
            if (bus.redirect_i) begin
                pc       <= {bus.redirectAddr_i[addressWidth-1:2], 2'b00};
                holdPc   <= '0;
                holdData <= '0;
                // An accepted-but-unanswered request must be drained before the next one.
                if (state == WAIT || state == DRAIN || (state == REQ && bus.icacheReady_i))
                    state <= DRAIN;
                else
                    state <= REQ;
            end else begin
                unique case (state)
                    IDLE:  state <= REQ;
                    REQ:   if (bus.icacheReady_i) state <= WAIT;
                    WAIT:  if (bus.icacheValid_i) begin
                               if (bus.queueFull_i) begin
                                   holdPc   <= pc;
                                   holdData <= bus.icacheData_i;
                                   state    <= STALL;
                               end else begin
                                   state <= REQ;
                               end
                           end
                    STALL: if (!bus.queueFull_i) state <= REQ;
                    DRAIN: if (bus.icacheValid_i) state <= REQ;
                    default: state <= IDLE;
                endcase
            end

            if (writeNow) begin
                bus.bundleWrite_o      <= 1'b1;
                bus.bundleAddress_o    <= srcPc;
                bus.bundleLen_o        <= ~srcOff;
                bus.bundlePid_o        <= bus.pid_i;
                bus.bundleTid_o        <= bus.tid_i;
                bus.bundleStartMajId_o <= majId;
                bus.bundle_o           <= srcData << (int'(srcOff) * instructionWidth);
                majId                  <= majId + instructionCounterWidth'(3'd4 - 3'(srcOff));
                pc                     <= {srcPc[addressWidth-1:4], 4'b0000} + addressWidth'(16);
            end
        end
    end
endmodule
